// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - hardwired Moore fetch/execute sequencer for the 5-bit-opcode register-bus CPU
// All outputs decode from state_q and IR_data only; start, stop and con_ff_bit steer next state.
module cpu_control_unit #(
    parameter int         MEM_WAIT = 1,
    parameter logic [4:0] OP_ADD   = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR_data,
    input  logic        con_ff_bit,
    input  logic        stop,
    input  logic        start,
    output logic        IRin,
    output logic        PCin,
    output logic        RYin,
    output logic        RZin,
    output logic        MARin,
    output logic        MDRin,
    output logic        HIin,
    output logic        LOin,
    output logic        Outport_in,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhi_out,
    output logic        Zlo_out,
    output logic        PCout,
    output logic        MDRout,
    output logic        Inport_out,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CONin,
    output logic        jump_n_link,
    output logic        IncPC,
    output logic [4:0]  opcode,
    output logic        Mem_read,
    output logic        Mem_write,
    output logic        run,
    output logic        illegal
);

    localparam logic [4:0] OPC_LD   = 5'd0;
    localparam logic [4:0] OPC_LDI  = 5'd1;
    localparam logic [4:0] OPC_ST   = 5'd2;
    localparam logic [4:0] OPC_ADD  = 5'd3;
    localparam logic [4:0] OPC_SHL  = 5'd11;
    localparam logic [4:0] OPC_ADDI = 5'd12;
    localparam logic [4:0] OPC_ORI  = 5'd14;
    localparam logic [4:0] OPC_DIV  = 5'd15;
    localparam logic [4:0] OPC_MUL  = 5'd16;
    localparam logic [4:0] OPC_NEG  = 5'd17;
    localparam logic [4:0] OPC_NOT  = 5'd18;
    localparam logic [4:0] OPC_BR   = 5'd19;
    localparam logic [4:0] OPC_JR   = 5'd20;
    localparam logic [4:0] OPC_JAL  = 5'd21;
    localparam logic [4:0] OPC_IN   = 5'd22;
    localparam logic [4:0] OPC_OUT  = 5'd23;
    localparam logic [4:0] OPC_MFHI = 5'd24;
    localparam logic [4:0] OPC_MFLO = 5'd25;
    localparam logic [4:0] OPC_NOP  = 5'd26;
    localparam logic [4:0] OPC_HALT = 5'd27;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_TW, S_T2, S_T3,
        S_E3, S_E4, S_E5, S_E6, S_E6_BR_T, S_LD_W, S_E7, S_ST_W, S_E8,
        S_HALTED
    } state_e;

    state_e     state_q, state_d;
    state_e     done_state;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       wait_last;

    logic [4:0] op;
    logic is_ld, is_ldi, is_st, is_alu3, is_imm, is_muldiv, is_unary;
    logic is_br, is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_nop;
    logic is_halt, is_bad, is_single;
    logic unused_ir;

    assign op        = IR_data[31:27];
    assign unused_ir = ^IR_data[26:0];
    assign is_ld     = (op == OPC_LD);
    assign is_ldi    = (op == OPC_LDI);
    assign is_st     = (op == OPC_ST);
    assign is_alu3   = (op >= OPC_ADD) && (op <= OPC_SHL);
    assign is_imm    = (op >= OPC_ADDI) && (op <= OPC_ORI);
    assign is_muldiv = (op == OPC_DIV) || (op == OPC_MUL);
    assign is_unary  = (op == OPC_NEG) || (op == OPC_NOT);
    assign is_br     = (op == OPC_BR);
    assign is_jr     = (op == OPC_JR);
    assign is_jal    = (op == OPC_JAL);
    assign is_in     = (op == OPC_IN);
    assign is_out    = (op == OPC_OUT);
    assign is_mfhi   = (op == OPC_MFHI);
    assign is_mflo   = (op == OPC_MFLO);
    assign is_nop    = (op == OPC_NOP);
    assign is_halt   = (op == OPC_HALT);
    assign is_bad    = (op[4:2] == 3'b111);
    assign is_single = is_jr | is_in | is_out | is_mfhi | is_mflo | is_nop;

    // stop only matters when an instruction retires
    assign done_state = stop ? S_HALTED : S_T0;
    assign wait_last  = (wait_cnt_q <= 3'd1);
    assign illegal    = illegal_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S_RST;
            wait_cnt_q <= 3'd0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        if (state_q == S_TW || state_q == S_LD_W || state_q == S_ST_W) begin
            wait_cnt_d = wait_last ? 3'd0 : wait_cnt_q - 3'd1;
        end
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1: begin
                if (MEM_WAIT == 0) begin
                    state_d = S_T2;
                end else begin
                    state_d    = S_TW;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            S_TW:  if (wait_last) state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3:  state_d = S_E3;
            S_E3: begin
                if (is_bad) begin
                    state_d   = S_HALTED;
                    illegal_d = 1'b1;
                end else if (is_halt) begin
                    state_d = S_HALTED;
                end else if (is_single) begin
                    state_d = done_state;
                end else begin
                    state_d = S_E4;
                end
            end
            S_E4: state_d = (is_unary || is_jal) ? done_state : S_E5;
            S_E5: begin
                if (is_alu3 || is_imm || is_ldi) begin
                    state_d = done_state;
                end else if (is_br) begin
                    state_d = con_ff_bit ? S_E6_BR_T : S_E6;
                end else begin
                    state_d = S_E6;
                end
            end
            S_E6: begin
                if (is_muldiv || is_br) begin
                    state_d = done_state;
                end else if (is_ld && MEM_WAIT != 0) begin
                    state_d    = S_LD_W;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = S_E7;
                end
            end
            S_LD_W: if (wait_last) state_d = S_E7;
            S_E7: begin
                if (is_ld) begin
                    state_d = S_E8;
                end else if (MEM_WAIT != 0) begin
                    state_d    = S_ST_W;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = done_state;
                end
            end
            S_ST_W:    if (wait_last) state_d = done_state;
            S_E8:      state_d = done_state;
            S_E6_BR_T: state_d = done_state;
            S_HALTED:  if (start) state_d = S_T0;
            default:   state_d = S_RST;
        endcase
    end

    always_comb begin
        {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in} = '0;
        {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, CONin, jump_n_link} = '0;
        IncPC     = 1'b0;
        Mem_read  = 1'b0;
        Mem_write = 1'b0;
        opcode    = OP_ADD;
        run       = 1'b1;
        case (state_q)
            S_RST: begin
                run    = 1'b0;
                opcode = 5'd0;
            end
            S_HALTED: run = 1'b0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
            end
            S_T1: begin
                Zlo_out = 1'b1; PCin = 1'b1; Mem_read = 1'b1;
            end
            S_TW: Mem_read = 1'b1;
            S_T2: begin
                Mem_read = 1'b1; MDRin = 1'b1;
            end
            S_T3: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_E3: begin
                if (is_alu3 || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; RYin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; RYin = 1'b1;
                end else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; opcode = op; RZin = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; RYin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (is_jal) begin
                    PCout = 1'b1; jump_n_link = 1'b1;
                end else if (is_in) begin
                    Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_out) begin
                    Gra = 1'b1; Rout = 1'b1; Outport_in = 1'b1;
                end else if (is_mfhi) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_mflo) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_E4: begin
                if (is_alu3) begin
                    Grc = 1'b1; Rout = 1'b1; opcode = op; RZin = 1'b1;
                end else if (is_imm) begin
                    Cout = 1'b1; opcode = op; RZin = 1'b1;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; opcode = op; RZin = 1'b1;
                end else if (is_unary) begin
                    Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    Cout = 1'b1; RZin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; RYin = 1'b1;
                end else if (is_jal) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            S_E5: begin
                if (is_alu3 || is_imm || is_ldi) begin
                    Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv) begin
                    Zlo_out = 1'b1; LOin = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlo_out = 1'b1; MARin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; RZin = 1'b1;
                end
            end
            S_E6: begin
                if (is_muldiv) begin
                    Zhi_out = 1'b1; HIin = 1'b1;
                end else if (is_ld) begin
                    Mem_read = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br) begin
                    Zlo_out = 1'b1;
                end
            end
            S_E6_BR_T: begin
                Zlo_out = 1'b1; PCin = 1'b1;
            end
            S_LD_W: Mem_read = 1'b1;
            S_E7: begin
                if (is_ld) begin
                    Mem_read = 1'b1; MDRin = 1'b1;
                end else begin
                    Mem_write = 1'b1;
                end
            end
            S_ST_W: Mem_write = 1'b1;
            S_E8: begin
                MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
